// File: rtl/instruction_fetch_pkg.sv
// Shared definitions for the instruction fetch stage: FSM encoding,
// PC increment and the instruction word that stops fetch.
package instruction_fetch_pkg;

  typedef enum logic {
    FETCH  = 1'b0,
    HALTED = 1'b1
  } fetch_state_e;

  localparam logic [63:0] PC_STEP   = 64'd4;
  localparam logic [31:0] HALT_WORD = 32'h0;

  function automatic logic [63:0] align_word(input logic [63:0] addr);
    return {addr[63:2], 2'b00};
  endfunction

  function automatic logic is_misaligned(input logic [63:0] addr);
    return |addr[1:0];
  endfunction

endpackage

// File: rtl/instruction_fetch_pc_register.sv
// Program counter register: synchronous reset to RESET_VAL, otherwise
// loads load_val when load_en is set and holds when it is clear.
module pc_register #(
  parameter int unsigned       WIDTH     = 64,
  parameter logic [WIDTH-1:0]  RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_en,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] value
);

  logic [WIDTH-1:0] value_q;
  logic [WIDTH-1:0] value_d;

  always_comb begin
    value_d = value_q;
    if (load_en) begin
      value_d = load_val;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      value_q <= RESET_VAL;
    end else begin
      value_q <= value_d;
    end
  end

  assign value = value_q;

endmodule

// File: rtl/instruction_fetch.sv
// Single-entry instruction fetch stage: reads imem at the PC, holds the word
// in an IF/ID register, handles redirects, stalls and halting on a zero word.
module instruction_fetch
  import instruction_fetch_pkg::*;
#(
  parameter logic [63:0] RESET_PC = 64'd0
) (
  input  logic        clk,
  input  logic        rst,
  output logic [63:0] imem_addr,
  input  logic [31:0] imem_data,
  input  logic        redirect_valid,
  input  logic [63:0] redirect_target,
  input  logic        id_ready,
  output logic        if_valid,
  output logic [31:0] if_instr,
  output logic [63:0] if_pc,
  output logic        halted,
  output logic        misalign_err
);

  // IF/ID handshake: the held word transfers to decode on any cycle where
  // if_valid && id_ready; if_valid && !id_ready is a stall and every IF/ID
  // field holds. A redirect beats both and flushes the held word.

  fetch_state_e state_q, state_d;
  logic         if_valid_q, if_valid_d;
  logic [31:0]  if_instr_q, if_instr_d;
  logic [63:0]  if_pc_q, if_pc_d;
  logic         misalign_err_q, misalign_err_d;

  logic [63:0]  pc;
  logic [63:0]  pc_load_val;
  logic         pc_load_en;
  logic         load_slot;

  pc_register #(
    .WIDTH     (64),
    .RESET_VAL (RESET_PC)
  ) u_pc_register (
    .clk      (clk),
    .rst      (rst),
    .load_en  (pc_load_en),
    .load_val (pc_load_val),
    .value    (pc)
  );

  assign load_slot = (state_q == FETCH) && (!if_valid_q || id_ready);

  always_comb begin
    state_d        = state_q;
    if_valid_d     = if_valid_q;
    if_instr_d     = if_instr_q;
    if_pc_d        = if_pc_q;
    misalign_err_d = 1'b0;
    pc_load_en     = 1'b0;
    pc_load_val    = pc;

    if (redirect_valid) begin
      pc_load_en     = 1'b1;
      pc_load_val    = align_word(redirect_target);
      if_valid_d     = 1'b0;
      state_d        = FETCH;
      misalign_err_d = is_misaligned(redirect_target);
    end else if (load_slot) begin
      if (imem_data == HALT_WORD) begin
        // PC stays on the halt word so a later redirect is the only way out.
        if_valid_d = 1'b0;
        state_d    = HALTED;
      end else begin
        if_instr_d  = imem_data;
        if_pc_d     = pc;
        if_valid_d  = 1'b1;
        pc_load_en  = 1'b1;
        pc_load_val = pc + PC_STEP;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= FETCH;
      if_valid_q     <= 1'b0;
      if_instr_q     <= '0;
      if_pc_q        <= '0;
      misalign_err_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      if_valid_q     <= if_valid_d;
      if_instr_q     <= if_instr_d;
      if_pc_q        <= if_pc_d;
      misalign_err_q <= misalign_err_d;
    end
  end

  assign imem_addr    = {2'b00, pc[63:2]};
  assign if_valid     = if_valid_q;
  assign if_instr     = if_instr_q;
  assign if_pc        = if_pc_q;
  assign halted       = (state_q == HALTED);
  assign misalign_err = misalign_err_q;

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch: a vector table for sequential fetch,
// stall, redirect and PC wrap, plus hand sequences for halt and reset cases.
module tb_instruction_fetch;

  logic        clk;
  logic        rst;
  logic [63:0] imem_addr;
  logic [31:0] imem_data;
  logic        redirect_valid;
  logic [63:0] redirect_target;
  logic        id_ready;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [63:0] if_pc;
  logic        halted;
  logic        misalign_err;

  int n_compared;
  int n_mismatched;

  logic [31:0] mem [0:63];

  instruction_fetch #(
    .RESET_PC (64'd0)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .imem_addr       (imem_addr),
    .imem_data       (imem_data),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .id_ready        (id_ready),
    .if_valid        (if_valid),
    .if_instr        (if_instr),
    .if_pc           (if_pc),
    .halted          (halted),
    .misalign_err    (misalign_err)
  );

  // Clock and reset-free clock generation
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Combinational instruction memory; addresses beyond the array return a
  // nonzero pattern so fetch never halts there.
  assign imem_data = (imem_addr < 64'd64) ? mem[imem_addr[5:0]]
                                          : {8'hC5, imem_addr[23:0]};

  function automatic logic [31:0] word(input int i);
    return 32'hA000_0000 | i;
  endfunction

  typedef struct packed {
    logic        rst;
    logic        redir;
    logic [63:0] target;
    logic        ready;
    logic        e_valid;
    logic [63:0] e_pc;
    logic [31:0] e_instr;
    logic        e_halted;
    logic        e_mis;
    logic [63:0] e_addr;
  } vec_t;

  function automatic vec_t mk(input logic r, input logic rv, input logic [63:0] t,
                              input logic rdy, input logic ev, input logic [63:0] ep,
                              input logic [31:0] ei, input logic eh, input logic em,
                              input logic [63:0] ea);
    vec_t v;
    v.rst = r; v.redir = rv; v.target = t; v.ready = rdy;
    v.e_valid = ev; v.e_pc = ep; v.e_instr = ei; v.e_halted = eh;
    v.e_mis = em; v.e_addr = ea;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_compared++;
    if (act !== exp) begin
      n_mismatched++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_all(input string tag, input logic ev, input logic [63:0] ep,
                           input logic [31:0] ei, input logic eh, input logic em,
                           input logic [63:0] ea);
    chk({tag, ".if_valid"},     {63'd0, if_valid},     {63'd0, ev});
    chk({tag, ".if_pc"},        if_pc,                 ep);
    chk({tag, ".if_instr"},     {32'd0, if_instr},     {32'd0, ei});
    chk({tag, ".halted"},       {63'd0, halted},       {63'd0, eh});
    chk({tag, ".misalign_err"}, {63'd0, misalign_err}, {63'd0, em});
    chk({tag, ".imem_addr"},    imem_addr,             ea);
  endtask

  // Drive inputs, take one rising edge, and settle before sampling.
  task automatic drive(input logic r, input logic rv, input logic [63:0] t, input logic rdy);
    rst = r; redirect_valid = rv; redirect_target = t; id_ready = rdy;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  vec_t vecs [17];
  logic [63:0] top_addr;

  initial begin
    n_compared   = 0;
    n_mismatched = 0;
    for (int i = 0; i < 64; i++) mem[i] = word(i);
    drive(1'b1, 1'b0, 64'd0, 1'b1);
    top_addr = 64'h3FFF_FFFF_FFFF_FFFF;

    //            rst  rv    target                  rdy   v     pc                      instr          h     m     addr
    vecs[0]  = mk(1'b1,1'b0, 64'h0,                  1'b1, 1'b0, 64'h0,                  32'h0,         1'b0, 1'b0, 64'd0);
    vecs[1]  = mk(1'b0,1'b0, 64'h0,                  1'b1, 1'b1, 64'h0,                  word(0),       1'b0, 1'b0, 64'd1);
    vecs[2]  = mk(1'b0,1'b0, 64'h0,                  1'b1, 1'b1, 64'h4,                  word(1),       1'b0, 1'b0, 64'd2);
    vecs[3]  = mk(1'b0,1'b0, 64'h0,                  1'b1, 1'b1, 64'h8,                  word(2),       1'b0, 1'b0, 64'd3);
    vecs[4]  = mk(1'b0,1'b0, 64'h0,                  1'b0, 1'b1, 64'h8,                  word(2),       1'b0, 1'b0, 64'd3);
    vecs[5]  = mk(1'b0,1'b0, 64'h0,                  1'b0, 1'b1, 64'h8,                  word(2),       1'b0, 1'b0, 64'd3);
    vecs[6]  = mk(1'b0,1'b0, 64'h0,                  1'b0, 1'b1, 64'h8,                  word(2),       1'b0, 1'b0, 64'd3);
    vecs[7]  = mk(1'b0,1'b0, 64'h0,                  1'b1, 1'b1, 64'hC,                  word(3),       1'b0, 1'b0, 64'd4);
    vecs[8]  = mk(1'b0,1'b0, 64'h0,                  1'b0, 1'b1, 64'hC,                  word(3),       1'b0, 1'b0, 64'd4);
    vecs[9]  = mk(1'b0,1'b1, 64'h1C,                 1'b0, 1'b0, 64'hC,                  word(3),       1'b0, 1'b0, 64'd7);
    vecs[10] = mk(1'b0,1'b0, 64'h0,                  1'b0, 1'b1, 64'h1C,                 word(7),       1'b0, 1'b0, 64'd8);
    vecs[11] = mk(1'b0,1'b0, 64'h0,                  1'b1, 1'b1, 64'h20,                 word(8),       1'b0, 1'b0, 64'd9);
    vecs[12] = mk(1'b0,1'b1, 64'h1E,                 1'b1, 1'b0, 64'h20,                 word(8),       1'b0, 1'b1, 64'd7);
    vecs[13] = mk(1'b0,1'b0, 64'h0,                  1'b1, 1'b1, 64'h1C,                 word(7),       1'b0, 1'b0, 64'd8);
    vecs[14] = mk(1'b0,1'b1, 64'hFFFF_FFFF_FFFF_FFFC,1'b1, 1'b0, 64'h1C,                 word(7),       1'b0, 1'b0, top_addr);
    vecs[15] = mk(1'b0,1'b0, 64'h0,                  1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFC,32'hC5FF_FFFF, 1'b0, 1'b0, 64'd0);
    vecs[16] = mk(1'b0,1'b0, 64'h0,                  1'b1, 1'b1, 64'h0,                  word(0),       1'b0, 1'b0, 64'd1);

    for (int i = 0; i < 17; i++) begin
      drive(vecs[i].rst, vecs[i].redir, vecs[i].target, vecs[i].ready);
      step();
      check_all($sformatf("vec%0d", i), vecs[i].e_valid, vecs[i].e_pc, vecs[i].e_instr,
                vecs[i].e_halted, vecs[i].e_mis, vecs[i].e_addr);
    end

    // Halt on zero word 5, stay halted, resume via redirect to 0.
    mem[5] = 32'h0;
    drive(1'b0, 1'b1, 64'h0, 1'b1);
    step();
    check_all("halt_redir", 1'b0, 64'h0, word(0), 1'b0, 1'b0, 64'd0);
    drive(1'b0, 1'b0, 64'h0, 1'b1);
    for (int k = 0; k < 5; k++) begin
      step();
      check_all($sformatf("halt_run%0d", k), 1'b1, 64'(4 * k), word(k), 1'b0, 1'b0,
                64'(k + 1));
    end
    step();
    check_all("halt_enter", 1'b0, 64'h10, word(4), 1'b1, 1'b0, 64'd5);
    for (int k = 0; k < 10; k++) begin
      step();
      check_all($sformatf("halt_hold%0d", k), 1'b0, 64'h10, word(4), 1'b1, 1'b0, 64'd5);
    end
    drive(1'b0, 1'b1, 64'h0, 1'b1);
    step();
    check_all("halt_exit", 1'b0, 64'h10, word(4), 1'b0, 1'b0, 64'd0);
    drive(1'b0, 1'b0, 64'h0, 1'b1);
    step();
    check_all("halt_resume", 1'b1, 64'h0, word(0), 1'b0, 1'b0, 64'd1);

    // Reset while halted, with a competing misaligned redirect.
    drive(1'b0, 1'b1, 64'h14, 1'b1);
    step();
    drive(1'b0, 1'b0, 64'h0, 1'b1);
    step();
    check_all("rh_halted", 1'b0, 64'h0, word(0), 1'b1, 1'b0, 64'd5);
    drive(1'b1, 1'b1, 64'h42, 1'b1);
    step();
    check_all("rh_reset", 1'b0, 64'h0, 32'h0, 1'b0, 1'b0, 64'd0);
    drive(1'b0, 1'b0, 64'h0, 1'b0);
    step();
    check_all("rh_restart", 1'b1, 64'h0, word(0), 1'b0, 1'b0, 64'd1);

    // Reset while stalled.
    step();
    check_all("rs_stall", 1'b1, 64'h0, word(0), 1'b0, 1'b0, 64'd1);
    drive(1'b1, 1'b0, 64'h0, 1'b0);
    step();
    check_all("rs_reset", 1'b0, 64'h0, 32'h0, 1'b0, 1'b0, 64'd0);
    drive(1'b0, 1'b0, 64'h0, 1'b0);
    step();
    check_all("rs_restart", 1'b1, 64'h0, word(0), 1'b0, 1'b0, 64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule

// File: doc/instruction_fetch.md
INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset: clk is the only clock, rst is sampled only on the rising edge of clk, and rst=1 resets the block.
REQ-002 The block SHALL have parameter RESET_PC, default 64'd0, meaning the byte address fetched first after reset.
REQ-003 Port clk, input, 1, rising-edge clock.
REQ-004 Port rst, input, 1, synchronous active-high reset.
REQ-005 Port imem_addr, output, 64, word index to instruction memory (pc >> 2).
REQ-006 Port imem_data, input, 32, instruction word returned combinationally for imem_addr.
REQ-007 Port redirect_valid, input, 1, branch/jump redirect request from execute.
REQ-008 Port redirect_target, input, 64, redirect byte address.
REQ-009 Port id_ready, input, 1, decode can accept the held instruction this cycle.
REQ-010 Port if_valid, output, 1, if_instr/if_pc hold a valid instruction.
REQ-011 Port if_instr, output, 32, registered instruction word.
REQ-012 Port if_pc, output, 64, byte address of if_instr.
REQ-013 Port halted, output, 1, fetch is stopped on a zero instruction word.
REQ-014 Port misalign_err, output, 1, one-cycle pulse when a redirect target has bits [1:0] != 0.

Function
REQ-015 The block SHALL implement two states: FETCH and HALTED; halted = (state == HALTED).
REQ-016 imem_addr SHALL be combinational: pc[63:2] zero-extended to 64 bits.
REQ-017 A load SHALL occur in FETCH when (!if_valid || id_ready) and redirect_valid=0.
REQ-018 On a load with imem_data != 0: if_instr<=imem_data, if_pc<=pc, if_valid<=1, pc<=pc+4 (modulo 2^64, wraps to 0).
REQ-019 On a load with imem_data == 32'h0: if_valid<=0, pc holds, state<=HALTED.
REQ-020 With if_valid=1 and id_ready=0, with no redirect, pc, if_pc, if_instr and if_valid SHALL hold (stall).
REQ-021 When if_valid=1 and id_ready=1 in the same cycle, the held instruction is consumed and the next one is loaded (back-to-back throughput is 1 per cycle).
REQ-022 redirect_valid=1 SHALL take priority over load, stall and HALTED.
REQ-023 On a redirect: pc<={redirect_target[63:2],2'b00}, if_valid<=0 (flush), state<=FETCH.
REQ-024 The first instruction from the redirect target SHALL appear with if_valid=1 on the cycle after the redirect.
REQ-025 misalign_err SHALL be 1 for exactly the cycle after a redirect whose target has [1:0] != 0, and 0 otherwise.
REQ-026 In HALTED, with no redirect, all outputs SHALL hold, with if_valid=0.
REQ-027 Address range checking against memory depth SHALL NOT be performed by this block.

Reset
REQ-028 On rst=1 at a clock edge: pc<=RESET_PC, state<=FETCH, if_valid<=0, if_instr<=0, if_pc<=0, misalign_err<=0; halted therefore reads 0.
REQ-029 rst SHALL override redirect_valid and id_ready, and SHALL discard any held instruction or HALTED state, including mid-stall.
REQ-030 The first if_valid=1 SHALL occur on the first edge after the edge where rst is deasserted.

Structure
REQ-031 The shared package SHALL hold the state encoding (FETCH, HALTED), the constant PC_STEP=64'd4, and the constant HALT_WORD=32'h0.
REQ-032 The block SHALL instantiate one sub-module, pc_register (64-bit register with synchronous reset value, load enable and load value), and SHALL keep the IF/ID output register and the FSM local.

Verification
REQ-033 RESET_PC=0, imem preloaded with nonzero words, id_ready=1: if_pc SHALL be 0,4,8,12 on consecutive cycles and imem_addr 0,1,2,3.
REQ-034 id_ready=0 for 3 cycles while if_valid=1 at if_pc=8: if_pc=8 and if_instr SHALL be unchanged throughout, and if_pc=12 SHALL follow one cycle after id_ready=1.
REQ-035 Redirect with target 0x1C during a stall: next cycle if_valid=0, then if_pc=0x1C with if_valid=1; misalign_err stays 0.
REQ-036 Redirect with target 0x1E: misalign_err pulses for 1 cycle and the next fetch is from if_pc=0x1C.
REQ-037 Word 5 = 0: after if_pc=16, halted=1 and if_valid=0 held for 10 cycles; a redirect to 0 then resumes with if_pc=0.
REQ-038 rst asserted while HALTED and while stalled: all outputs are at reset values on the next cycle, and fetch restarts at RESET_PC.
